// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, execute redirect, decode output slot and trap report.
// master = fetch_unit, slave = memory/execute/decode side.
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic            trap;
    logic [XLEN-1:0] trap_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output trap,
        output trap_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  trap,
        input  trap_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers fetched words for decode, traps on misaligned redirects.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_stall counters.
//
// state | meaning
// BOOT  | one idle cycle after reset release while the memory settles
// FETCH | normal fetch, redirect and stall handling
// TRAP  | misaligned redirect seen; frozen until reset
module fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_TRAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] tpc_q, tpc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            trap_q  <= 1'b0;
            tpc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
            trap_q  <= trap_d;
            tpc_q   <= tpc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        trap_d  = trap_q;
        tpc_d   = tpc_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                // Redirect beats both capture and stall; the slot is flushed even under backpressure.
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    if (bus.redirect_target[1:0] == 2'b00) begin
                        pc_d = bus.redirect_target;
                    end else begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        tpc_d   = bus.redirect_target;
                    end
                end else if (!valid_q || bus.out_ready) begin
                    instr_d = bus.imem_rdata;
                    opc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + XLEN'(4);
                end
            end
            S_TRAP:  valid_d = 1'b0;
            default: state_d = S_BOOT;
        endcase
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = opc_q;
    assign bus.trap      = trap_q;
    assign bus.trap_pc   = tpc_q;

`ifdef FETCH_PERF_EN
    logic        in_fetch;
    logic        take;
    logic        stall;
    logic [31:0] fetched_q, stall_q;

    assign in_fetch = (state_q == S_FETCH) && !bus.redirect_valid;
    assign take     = in_fetch && (!valid_q || bus.out_ready);
    assign stall    = in_fetch && valid_q && !bus.out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (take)  fetched_q <= fetched_q + 32'd1;
            if (stall) stall_q   <= stall_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall   = stall_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory.
- Owns the program counter and drives the memory address, which is a combinational read with RD valid in the same cycle.
- Registers each fetched instruction with its PC into an output slot for decode, using a valid/ready handshake.
- Accepts branch/jump redirects from execute and traps on misaligned targets.

Parameters:
- RESET_VECTOR, 32'h00000000, PC value loaded on reset.
- XLEN, 32, address/instruction width (only 32 supported).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset asserted).
- imem_addr  output  XLEN  byte address to instruction memory; equals pc.
- imem_rdata  input  XLEN  instruction word returned combinationally for imem_addr.
- redirect_valid  input  1  execute requests PC change this cycle.
- redirect_target  input  XLEN  new PC when redirect_valid=1.
- out_valid  output  1  output slot holds a valid instruction.
- out_ready  input  1  decode accepts the slot this cycle.
- out_instr  output  XLEN  registered instruction word.
- out_pc  output  XLEN  PC of out_instr.
- trap  output  1  misaligned redirect target detected; sticky until reset.
- trap_pc  output  XLEN  offending target address.

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VECTOR, state=BOOT, out_valid=0, out_instr=0, out_pc=0, trap=0, trap_pc=0. imem_addr follows pc, so it equals RESET_VECTOR.
- States:
  - BOOT: one idle cycle after rst deasserts (memory settles out of its own reset). Always goes to FETCH next; no capture.
  - FETCH: normal operation.
  - TRAP: terminal until reset.
- Capture condition (FETCH only): take = (!out_valid || out_ready) && !redirect_valid.
- On take, at the clock edge: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - pc arithmetic is modulo 2^32; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- Stall: out_valid=1 && out_ready=0 && !redirect_valid → pc, out_instr and out_pc hold; no memory word is lost.
- Consume without refill is not possible in FETCH: a take always refills, giving back-to-back throughput of 1 instruction/cycle.
- Redirect (FETCH, redirect_valid=1, highest priority, overrides take and stall):
  - target[1:0]==2'b00: pc<=redirect_target and out_valid<=0 (the slot is flushed even if out_ready=0). The first instruction from the target appears the following cycle, so the redirect bubble is exactly 1 cycle.
  - target[1:0]!=0: state<=TRAP, trap<=1, trap_pc<=redirect_target, out_valid<=0, pc holds.
- redirect_valid in BOOT or TRAP: ignored.
- TRAP: out_valid=0, pc frozen, imem_addr frozen; only rst exits.
- Reset mid-operation: all state returns to reset values immediately, regardless of the clock. An in-flight slot is discarded.
- out_instr/out_pc are only meaningful when out_valid=1; they retain their last value otherwise.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output ports perf_fetched (32-bit) and perf_stall (32-bit), both reset to 0.
  - perf_fetched increments on every take.
  - perf_stall increments each FETCH cycle with out_valid=1 && out_ready=0 && !redirect_valid.
  - Both counters wrap at 2^32.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Memory preload: [0]=0x0062E233, [4]=0x00B67433, [8]=0x00B60433.
1. Reset then boot: hold rst=0 for 2 cycles, out_ready=1 → out_valid=0 and imem_addr=0 during reset and BOOT. On the 2nd edge after release, out_instr=0x0062E233, out_pc=0. Then 0x00B67433/4 and 0x00B60433/8 follow on consecutive cycles.
2. Backpressure: out_ready=0 for 3 cycles while out_instr=0x00B67433 → out_instr, out_pc=4 and imem_addr=8 stable. Raise out_ready → next edge gives 0x00B60433/8.
3. Redirect with stalled slot: out_valid=1, out_ready=0, redirect_valid=1, target=0x00000004 → next cycle out_valid=0, imem_addr=4. The cycle after that, out_instr=0x00B67433, out_pc=4.
4. Misaligned redirect: target=0x00000006 → trap=1, trap_pc=6, out_valid=0 and pc frozen. Further redirects are ignored until rst=0, which clears trap.
5. Async reset mid-stream: assert rst=0 between clock edges while out_valid=1 → out_valid=0, imem_addr=0 and trap=0 immediately, without waiting for a clock edge.
6. FETCH_PERF_EN: run case 2 → perf_stall=3 and perf_fetched=3 after the three instructions are taken.
